// File: rtl/qhttp_teleport_initiator_if.sv
// qhttp teleport initiator bus: host request, Instaweb frame link,
// QCI EPR/Bell control and completion status.
interface qhttp_teleport_initiator_if;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_qubit_id;
    logic [7:0]   req_priority;
    logic         emergency_override;
    logic [63:0]  now_cycles;
    logic [511:0] instaweb_rx_data;
    logic         instaweb_rx_valid;
    logic [511:0] instaweb_tx_data;
    logic         instaweb_tx_valid;
    logic [127:0] qubit_id;
    logic         qubit_ready;
    logic [63:0]  coherence_deadline;
    logic         bell_start;
    logic [127:0] bell_qubit_id;
    logic         bell_done;
    logic [1:0]   bell_result;
    logic         done_valid;
    logic [2:0]   done_status;

    modport master (
        output req_valid, req_qubit_id, req_priority, emergency_override,
        output now_cycles, instaweb_rx_data, instaweb_rx_valid,
        output qubit_id, qubit_ready, coherence_deadline,
        output bell_done, bell_result,
        input  req_ready, instaweb_tx_data, instaweb_tx_valid,
        input  bell_start, bell_qubit_id, done_valid, done_status
    );

    modport slave (
        input  req_valid, req_qubit_id, req_priority, emergency_override,
        input  now_cycles, instaweb_rx_data, instaweb_rx_valid,
        input  qubit_id, qubit_ready, coherence_deadline,
        input  bell_done, bell_result,
        output req_ready, instaweb_tx_data, instaweb_tx_valid,
        output bell_start, bell_qubit_id, done_valid, done_status
    );
endinterface

// File: rtl/qhttp_teleport_initiator.sv
// Sender-side qhttp teleportation engine: entanglement request, EPR
// pairing, Bell measurement hand-off and coherence-deadline enforcement.
module qhttp_teleport_initiator #(
    parameter int unsigned PRIO_LIMIT  = 100,
    parameter int unsigned EPR_TIMEOUT = 4096
) (
    input logic                        clk_1g,
    input logic                        rst_n,
    qhttp_teleport_initiator_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, SEND_REQ, WAIT_EPR, MEASURE, SEND_BELL, WAIT_ACK, ABORT
    } state_t;

    localparam logic [7:0] T_REQ   = 8'h01;
    localparam logic [7:0] T_EPR   = 8'h02;
    localparam logic [7:0] T_BELL  = 8'h03;
    localparam logic [7:0] T_ACK   = 8'h04;
    localparam logic [7:0] T_ABORT = 8'h05;

    localparam logic [2:0] ST_OK  = 3'd0;
    localparam logic [2:0] ST_REJ = 3'd1;
    localparam logic [2:0] ST_TMO = 3'd2;
    localparam logic [2:0] ST_DEC = 3'd3;

    localparam int         CW   = $clog2(EPR_TIMEOUT) + 1;
    localparam logic [7:0] PLIM = PRIO_LIMIT[7:0];
    localparam logic [CW-1:0] CLAST = CW'(EPR_TIMEOUT - 1);

    function automatic logic [511:0] mk_frame(
        input logic [7:0]   t,
        input logic [7:0]   p,
        input logic [127:0] id,
        input logic [1:0]   b
    );
        logic [511:0] f;
        f            = '0;
        f[7:0]       = t;
        f[23:16]     = p;
        f[159:32]    = id;
        f[161:160]   = b;
        return f;
    endfunction

    state_t        state, state_n;
    logic [127:0]  id_q, id_n;
    logic [7:0]    prio_q, prio_n;
    logic [63:0]   dl_q, dl_n;
    logic          epr_r, epr_r_n;
    logic          epr_l, epr_l_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    code_q, code_n;
    logic [511:0]  tx_data_q, tx_data_n;
    logic          tx_valid_q, tx_valid_n;
    logic          bstart_q, bstart_n;
    logic          dvalid_q, dvalid_n;
    logic [2:0]    dstatus_q, dstatus_n;
    logic          ready_q, ready_n;

    logic [7:0] rx_type;
    logic       rx_hit, loc_hit, dl_hit, peer_abort, accept;

    assign rx_type    = bus.instaweb_rx_data[7:0];
    assign rx_hit     = bus.instaweb_rx_valid &&
                        (bus.instaweb_rx_data[159:32] == id_q);
    assign loc_hit    = bus.qubit_ready && (bus.qubit_id == id_q);
    assign dl_hit     = bus.now_cycles >= dl_q;
    assign peer_abort = rx_hit && (rx_type == T_ABORT);
    assign accept     = bus.req_valid && ready_q;

    always_comb begin
        state_n    = state;
        id_n       = id_q;
        prio_n     = prio_q;
        dl_n       = dl_q;
        epr_r_n    = epr_r;
        epr_l_n    = epr_l;
        cnt_n      = cnt;
        code_n     = code_q;
        tx_data_n  = '0;
        tx_valid_n = 1'b0;
        bstart_n   = 1'b0;
        dvalid_n   = 1'b0;
        dstatus_n  = dstatus_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    id_n   = bus.req_qubit_id;
                    prio_n = bus.req_priority;
                    if (bus.req_priority > PLIM && !bus.emergency_override) begin
                        dvalid_n  = 1'b1;
                        dstatus_n = ST_REJ;
                    end else begin
                        state_n    = SEND_REQ;
                        tx_valid_n = 1'b1;
                        tx_data_n  = mk_frame(T_REQ, bus.req_priority,
                                              bus.req_qubit_id, 2'b00);
                    end
                end
            end
            SEND_REQ: begin
                epr_r_n = 1'b0;
                epr_l_n = 1'b0;
                cnt_n   = '0;
                state_n = WAIT_EPR;
            end
            WAIT_EPR: begin
                if (peer_abort) begin
                    state_n   = IDLE;
                    dvalid_n  = 1'b1;
                    dstatus_n = ST_DEC;
                end else begin
                    epr_r_n = epr_r || (rx_hit && rx_type == T_EPR);
                    epr_l_n = epr_l || loc_hit;
                    if (loc_hit) dl_n = bus.coherence_deadline;
                    if (epr_r_n && epr_l_n) begin
                        state_n  = MEASURE;
                        bstart_n = 1'b1;
                    end else if (cnt == CLAST) begin
                        state_n    = ABORT;
                        code_n     = ST_TMO;
                        tx_valid_n = 1'b1;
                        tx_data_n  = mk_frame(T_ABORT, prio_q, id_q, 2'b00);
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            MEASURE, SEND_BELL, WAIT_ACK: begin
                // Deadline outranks a bell_done or ack landing the same cycle.
                if (peer_abort) begin
                    state_n   = IDLE;
                    dvalid_n  = 1'b1;
                    dstatus_n = ST_DEC;
                end else if (dl_hit) begin
                    state_n    = ABORT;
                    code_n     = ST_DEC;
                    tx_valid_n = 1'b1;
                    tx_data_n  = mk_frame(T_ABORT, prio_q, id_q, 2'b00);
                end else if (state == MEASURE) begin
                    if (bus.bell_done) begin
                        state_n    = SEND_BELL;
                        tx_valid_n = 1'b1;
                        tx_data_n  = mk_frame(T_BELL, prio_q, id_q,
                                              bus.bell_result);
                    end
                end else if (state == SEND_BELL) begin
                    state_n = WAIT_ACK;
                end else if (rx_hit && rx_type == T_ACK) begin
                    state_n   = IDLE;
                    dvalid_n  = 1'b1;
                    dstatus_n = ST_OK;
                end
            end
            ABORT: begin
                state_n   = IDLE;
                dvalid_n  = 1'b1;
                dstatus_n = code_q;
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk_1g or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            id_q       <= '0;
            prio_q     <= '0;
            dl_q       <= '0;
            epr_r      <= 1'b0;
            epr_l      <= 1'b0;
            cnt        <= '0;
            code_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            bstart_q   <= 1'b0;
            dvalid_q   <= 1'b0;
            dstatus_q  <= '0;
            ready_q    <= 1'b0;
        end else begin
            state      <= state_n;
            id_q       <= id_n;
            prio_q     <= prio_n;
            dl_q       <= dl_n;
            epr_r      <= epr_r_n;
            epr_l      <= epr_l_n;
            cnt        <= cnt_n;
            code_q     <= code_n;
            tx_data_q  <= tx_data_n;
            tx_valid_q <= tx_valid_n;
            bstart_q   <= bstart_n;
            dvalid_q   <= dvalid_n;
            dstatus_q  <= dstatus_n;
            ready_q    <= ready_n;
        end
    end

    assign bus.req_ready         = ready_q;
    assign bus.instaweb_tx_data  = tx_data_q;
    assign bus.instaweb_tx_valid = tx_valid_q;
    assign bus.bell_start        = bstart_q;
    assign bus.bell_qubit_id     = id_q;
    assign bus.done_valid        = dvalid_q;
    assign bus.done_status       = dstatus_q;
endmodule

// File: tb/tb_qhttp_teleport_initiator.sv
// Directed bench for qhttp_teleport_initiator: happy path, priority gate,
// EPR timeout, EPR ordering, decoherence abort and mid-flight reset.
`timescale 1ns/1ps
module tb_qhttp_teleport_initiator;
    logic clk_1g = 1'b0;
    logic rst_n  = 1'b0;
    always #1 clk_1g = ~clk_1g;

    qhttp_teleport_initiator_if bus();

    qhttp_teleport_initiator dut (
        .clk_1g (clk_1g),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    longint unsigned cyc = 0;
    always @(posedge clk_1g) cyc <= cyc + 1;
    assign bus.now_cycles = cyc;

    logic [511:0]    txq[$];
    longint unsigned tx_cyc[$];
    int              done_n = 0;
    int              bell_n = 0;
    logic [2:0]      last_status = '0;
    longint unsigned done_cyc = 0;

    always @(posedge clk_1g) begin
        #0.2;
        if (bus.instaweb_tx_valid) begin
            txq.push_back(bus.instaweb_tx_data);
            tx_cyc.push_back(cyc);
        end
        if (bus.done_valid) begin
            done_n++;
            last_status = bus.done_status;
            done_cyc = cyc;
        end
        if (bus.bell_start) bell_n++;
    end

    function automatic logic [511:0] mk(input logic [7:0] t, input logic [7:0] p,
                                        input logic [127:0] id, input logic [1:0] b);
        logic [511:0] f;
        f = '0;
        f[7:0] = t;
        f[23:16] = p;
        f[159:32] = id;
        f[161:160] = b;
        return f;
    endfunction

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_1g);
            #0.5;
        end
    endtask

    longint unsigned req_cyc, rx_cyc;

    task automatic request(input logic [127:0] id, input logic [7:0] p,
                           input logic ovr);
        step(1);
        bus.req_valid = 1'b1;
        bus.req_qubit_id = id;
        bus.req_priority = p;
        bus.emergency_override = ovr;
        req_cyc = cyc;
        step(1);
        bus.req_valid = 1'b0;
        bus.emergency_override = 1'b0;
    endtask

    task automatic rx(input logic [7:0] t, input logic [127:0] id);
        step(1);
        bus.instaweb_rx_data = mk(t, 8'd0, id, 2'b00);
        bus.instaweb_rx_valid = 1'b1;
        rx_cyc = cyc;
        step(1);
        bus.instaweb_rx_valid = 1'b0;
        bus.instaweb_rx_data = '0;
    endtask

    task automatic local_epr(input logic [127:0] id, input logic [63:0] dl);
        step(1);
        bus.qubit_id = id;
        bus.coherence_deadline = dl;
        bus.qubit_ready = 1'b1;
        step(1);
        bus.qubit_ready = 1'b0;
    endtask

    task automatic bell(input logic [1:0] r);
        step(1);
        bus.bell_done = 1'b1;
        bus.bell_result = r;
        step(1);
        bus.bell_done = 1'b0;
    endtask

    int t0, d0, b0;
    logic [63:0] dl;
    longint unsigned a_cyc;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_qubit_id = '0;
        bus.req_priority = '0;
        bus.emergency_override = 1'b0;
        bus.instaweb_rx_data = '0;
        bus.instaweb_rx_valid = 1'b0;
        bus.qubit_id = '0;
        bus.qubit_ready = 1'b0;
        bus.coherence_deadline = '0;
        bus.bell_done = 1'b0;
        bus.bell_result = '0;

        step(3);
        check("rst_ready", bus.req_ready, 0);
        check("rst_tx_valid", bus.instaweb_tx_valid, 0);
        check("rst_done_valid", bus.done_valid, 0);
        rst_n = 1'b1;
        step(2);
        check("idle_ready", bus.req_ready, 1);

        // happy path
        request(128'hA5, 8'd10, 1'b0);
        step(2);
        check("hp_tx_cnt1", txq.size(), 1);
        check("hp_req_frame", txq[0], mk(8'h01, 8'd10, 128'hA5, 2'b00));
        check("hp_req_lat", tx_cyc[0] - req_cyc, 1);
        rx(8'h02, 128'hA5);
        local_epr(128'hA5, cyc + 1000);
        step(3);
        check("hp_bell_start", bell_n, 1);
        check("hp_bell_id", bus.bell_qubit_id, 128'hA5);
        bell(2'b10);
        step(3);
        check("hp_tx_cnt2", txq.size(), 2);
        check("hp_bell_frame", txq[1], mk(8'h03, 8'd10, 128'hA5, 2'b10));
        rx(8'h04, 128'hA5);
        step(2);
        check("hp_done_cnt", done_n, 1);
        check("hp_status", last_status, 0);
        check("hp_ack_lat", done_cyc - rx_cyc, 1);
        check("hp_ready", bus.req_ready, 1);

        // priority gate
        d0 = done_n;
        t0 = txq.size();
        request(128'h11, 8'd200, 1'b0);
        step(3);
        check("prio_rej_done", done_n, d0 + 1);
        check("prio_rej_status", last_status, 1);
        check("prio_rej_no_tx", txq.size(), t0);
        request(128'h12, 8'd200, 1'b1);
        step(2);
        check("prio_ovr_tx", txq.size(), t0 + 1);
        check("prio_ovr_frame", txq[t0], mk(8'h01, 8'd200, 128'h12, 2'b00));
        rx(8'h05, 128'h12);
        step(2);
        check("peer_abort_status", last_status, 3);
        check("peer_abort_no_tx", txq.size(), t0 + 1);

        // EPR timeout, with wrong-id EPR traffic that must be ignored
        t0 = txq.size();
        d0 = done_n;
        request(128'h33, 8'd5, 1'b0);
        step(5);
        rx(8'h02, 128'h34);
        local_epr(128'h34, 64'hFFFF_FFFF_FFFF_FFFF);
        begin
            int k = 0;
            while (txq.size() < t0 + 2 && k < 5000) begin
                step(1);
                k++;
            end
            check("tmo_bound", (txq.size() >= t0 + 2), 1);
        end
        check("tmo_bell_none", bell_n, 1);
        check("tmo_abort_frame", txq[t0 + 1], mk(8'h05, 8'd5, 128'h33, 2'b00));
        check("tmo_elapsed", tx_cyc[t0 + 1] - tx_cyc[t0], 4097);
        step(3);
        check("tmo_done", done_n, d0 + 1);
        check("tmo_status", last_status, 2);
        check("tmo_ready", bus.req_ready, 1);

        // ordering: local half first, then remote
        request(128'h44, 8'd5, 1'b0);
        step(2);
        b0 = bell_n;
        local_epr(128'h44, cyc + 100000);
        step(2);
        check("ord_local_only", bell_n, b0);
        rx(8'h02, 128'h44);
        step(2);
        check("ord_local_first", bell_n, b0 + 1);
        rx(8'h05, 128'h44);
        step(2);

        // ordering: both halves in the same cycle
        request(128'h55, 8'd5, 1'b0);
        step(2);
        b0 = bell_n;
        step(1);
        bus.instaweb_rx_data = mk(8'h02, 8'd0, 128'h55, 2'b00);
        bus.instaweb_rx_valid = 1'b1;
        bus.qubit_id = 128'h55;
        bus.coherence_deadline = cyc + 100000;
        bus.qubit_ready = 1'b1;
        step(1);
        bus.instaweb_rx_valid = 1'b0;
        bus.qubit_ready = 1'b0;
        step(2);
        check("ord_same_cycle", bell_n, b0 + 1);
        rx(8'h05, 128'h55);
        step(2);

        // decoherence with ack arriving on the deadline cycle
        request(128'h66, 8'd10, 1'b0);
        step(2);
        rx(8'h02, 128'h66);
        dl = cyc + 50;
        local_epr(128'h66, dl);
        bell(2'b01);
        step(3);
        check("dec_bell_frame", txq[txq.size() - 1], mk(8'h03, 8'd10, 128'h66, 2'b01));
        t0 = txq.size();
        d0 = done_n;
        while (cyc < dl) step(1);
        check("dec_no_early", done_n, d0);
        bus.instaweb_rx_data = mk(8'h04, 8'd0, 128'h66, 2'b00);
        bus.instaweb_rx_valid = 1'b1;
        a_cyc = cyc;
        step(1);
        bus.instaweb_rx_valid = 1'b0;
        bus.instaweb_rx_data = '0;
        step(3);
        check("dec_tx_cnt", txq.size(), t0 + 1);
        check("dec_abort_frame", txq[t0], mk(8'h05, 8'd10, 128'h66, 2'b00));
        check("dec_abort_lat", tx_cyc[t0] - a_cyc, 1);
        check("dec_done", done_n, d0 + 1);
        check("dec_status", last_status, 3);

        // reset while waiting for the ack
        request(128'h77, 8'd10, 1'b0);
        step(2);
        rx(8'h02, 128'h77);
        local_epr(128'h77, cyc + 100000);
        bell(2'b11);
        step(3);
        t0 = txq.size();
        d0 = done_n;
        step(1);
        rst_n = 1'b0;
        #0.1;
        check("mrst_tx_valid", bus.instaweb_tx_valid, 0);
        check("mrst_tx_data", bus.instaweb_tx_data, 0);
        check("mrst_done_valid", bus.done_valid, 0);
        check("mrst_bell_start", bus.bell_start, 0);
        check("mrst_ready", bus.req_ready, 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("mrst_no_abort", txq.size(), t0);
        check("mrst_no_done", done_n, d0);
        check("mrst_ready_after", bus.req_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
